// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC source encodings and fetch address constants shared with CP0
package pc_unit_pkg;
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch control inputs and fetch address outputs of the PC unit
interface pc_unit_if #(parameter int WIDTH = 32, parameter int CNT_W = 32);
  logic             stall, exc_req, eret_req, fetch_err;
  logic [1:0]       npc_sel;
  logic [WIDTH-1:0] target, epc, pc, pc_plus4, pc_plus8;
  logic [CNT_W-1:0] fetch_count;
  modport master (output stall, npc_sel, target, exc_req, eret_req, epc,
                  input pc, pc_plus4, pc_plus8, fetch_err, fetch_count);
  modport slave (input stall, npc_sel, target, exc_req, eret_req, epc,
                 output pc, pc_plus4, pc_plus8, fetch_err, fetch_count);
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: fixed-priority next-PC mux with load enable
module pc_next_sel import pc_unit_pkg::*; #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] EXC_PC = WIDTH'(DEF_EXC_PC)
) (
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic             stall,
  input  logic [1:0]       npc_sel,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] epc,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic             load
);
  always_comb begin
    next_pc = exc_req ? EXC_PC : eret_req ? epc : (npc_sel == NPC_SEQ) ? pc + WIDTH'(4) : target;
    load    = exc_req | eret_req | ~stall;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with redirect selection, fault flag and load counter
module pc_unit import pc_unit_pkg::*; #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(DEF_EXC_PC),
  parameter logic [WIDTH-1:0] TEXT_LO  = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] TEXT_HI  = WIDTH'(32'h0000_4FFC),
  parameter int               CNT_W    = 32
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);
  logic [WIDTH-1:0] pc_q, next_pc;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q, load, bad;
  pc_next_sel #(.WIDTH(WIDTH), .EXC_PC(EXC_PC)) u_sel (
    .exc_req (bus.exc_req),
    .eret_req(bus.eret_req),
    .stall   (bus.stall),
    .npc_sel (bus.npc_sel),
    .target  (bus.target),
    .epc     (bus.epc),
    .pc      (pc_q),
    .next_pc (next_pc),
    .load    (load)
  );
  // fault is judged on the incoming address so it lands together with it
  assign bad = (next_pc[1:0] != 2'b00) || (next_pc < TEXT_LO) || (next_pc > TEXT_HI);
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      pc_q  <= next_pc;
      err_q <= bad;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + WIDTH'(4);
  assign bus.pc_plus8    = pc_q + WIDTH'(8);
  assign bus.fetch_err   = err_q;
  assign bus.fetch_count = cnt_q;
endmodule
